instr_prog_loader: RTL and testbench
====================================

Name: instr_prog_loader

Overview:
- Write-side counterpart of the instruction ROM.
- Accepts decoded instruction fields over a valid/ready stream, encodes each into a 9-bit word and writes it sequentially into an internal 2^ADDR_W-entry instruction RAM.
- A PC-indexed read port returns the same decoded fields the datapath expects (format, opcode, sign, operand, immediate).
- A testbench or host can load a program at run time instead of using a fixed ROM.

Parameters:
ADDR_W, 7, RAM address width; depth = 2^ADDR_W (128 words).
WORD_W, 9, instruction width; fixed at 9, and other values are unsupported.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a new load session; single-cycle pulse
in_valid  in  1  input beat valid
in_ready  out  1  loader can accept a beat
in_format  in  1  becomes word bit 8
in_use_imm  in  1  1: bits 7:0 = in_immediate; 0: bits 7:0 = {in_opcode, in_sign, in_operand}
in_opcode  in  4  opcode field
in_sign  in  1  sign field
in_operand  in  3  operand field
in_immediate  in  8  immediate field
in_last  in  1  marks the final beat of the program
busy  out  1  high in LOAD
done  out  1  high in DONE
overflow  out  1  RAM filled without in_last
wr_count  out  ADDR_W+1  number of words written this session
pc_in  in  16  read address
format  out  1  rd_word[8]
opcode  out  4  rd_word[7:4]
sign  out  1  rd_word[3]
operand  out  3  rd_word[2:0]
immediate  out  8  rd_word[7:0]

Behaviour:
- Reset values: state=IDLE, wr_count=0, busy=0, done=0, overflow=0, in_ready=0, rd_word=0 (all field outputs 0). Reset is asynchronous and may assert at any time, including mid-load. RAM contents are not cleared; they are masked by wr_count.
- FSM states:
  - IDLE: start -> LOAD.
  - LOAD: busy=1, in_ready=1. Beats are accepted on in_valid && in_ready.
    - Accepted beat writes enc_word to mem[wr_count[ADDR_W-1:0]] and increments wr_count.
    - Accepted beat with in_last=1 -> DONE.
    - Accepted beat that makes wr_count = 2^ADDR_W with in_last=0 -> DONE and sets overflow=1.
    - Accepted beat that fills the RAM with in_last=1 -> DONE, overflow=0.
    - start is ignored while in LOAD.
  - DONE: done=1, in_ready=0. start -> LOAD.
- Any transition into LOAD clears wr_count and overflow on the same edge.
- Encoding: enc_word = {in_format, in_use_imm ? in_immediate : {in_opcode, in_sign, in_operand}}.
- Read port:
  - Synchronous, 1-cycle latency: rd_word registers on each clk edge.
  - rd_word = (pc_in < wr_count) ? mem[pc_in] : 9'b0. The comparison uses the full 16-bit pc_in, so any pc_in >= 2^ADDR_W returns 0, which is a NOP.
  - Read-before-write: a same-cycle write to address A and read of A returns 0, because the comparison uses the pre-increment wr_count. The new word is visible on the next read.
  - Field outputs are pure slices of rd_word. Immediate overlaps opcode/sign/operand by definition.
- in_ready is a registered function of state only. It does not depend combinationally on in_valid.
- A beat presented while in_ready=0 is not consumed, and in_valid may stay high.
- Reset during LOAD sets wr_count=0, so all reads return 0 until a new load completes.

Test Plan:
- Reset, start, then 3 beats {fmt0, imm 0x00}, {fmt1, op 0x7, sign 1, operand 0}, {fmt0, imm 0x80, last}. Required: done=1, wr_count=3. Reads of pc 0/1/2 return words 0x000/0x178/0x080; pc 1 gives format=1, opcode=7, sign=1, operand=0. pc 3 returns 0.
- Drive in_valid high continuously for 128 beats with in_last=0. Required: in_ready drops after beat 128, wr_count=128, overflow=1, done=1. Beat 129 is not consumed, and pc_in=200 returns 0.
- Toggle in_valid every other cycle for 5 beats. Required: exactly 5 writes, wr_count=5, no duplicated or skipped addresses.
- Assert reset after 10 of 20 beats. Required: all outputs return to reset values asynchronously and a pc 0 read returns 0. A fresh load of 2 words then succeeds with wr_count=2.
- Pulse start while in LOAD at wr_count=4. Required: no effect and loading continues. Pulse start in DONE. Required: wr_count=0, overflow=0, LOAD re-entered.
- Write address 0 and read pc_in=0 on the same cycle. Required: 0 on the next cycle, and the written word one cycle later.

Source files
------------

// File: rtl/instr_prog_loader.sv
`default_nettype none
// ============================================================================
// instr_prog_loader : streams decoded instruction fields into a 2^ADDR_W x 9
//                     instruction RAM and serves them back on a PC read port.
// Revision 1.0
// ============================================================================
module instr_prog_loader #(
  parameter int ADDR_W = 7,
  parameter int WORD_W = 9  // only 9 is supported
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_format,
  input  logic              in_use_imm,
  input  logic [3:0]        in_opcode,
  input  logic              in_sign,
  input  logic [2:0]        in_operand,
  input  logic [7:0]        in_immediate,
  input  logic              in_last,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   wr_count,
  input  logic [15:0]       pc_in,
  output logic              format,
  output logic [3:0]        opcode,
  output logic              sign,
  output logic [2:0]        operand,
  output logic [7:0]        immediate
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     wr_count_q, wr_count_d;
  logic                overflow_q, overflow_d;
  logic [WORD_W-1:0]   rd_word_q, rd_word_d;
  logic [WORD_W-1:0]   mem [DEPTH];
  logic [WORD_W-1:0]   enc_word;
  logic [15:0]         wr_count_ext;
  logic                accept;

  assign accept       = in_valid && (state_q == LOAD);
  assign enc_word     = {in_format, in_use_imm ? in_immediate : {in_opcode, in_sign, in_operand}};
  assign wr_count_ext = {{(15 - ADDR_W){1'b0}}, wr_count_q};

  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LOAD;
          wr_count_d = '0;
          overflow_d = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          wr_count_d = wr_count_q + 1'b1;
          if (in_last) begin
            state_d = DONE;
          end else if (wr_count_q == LAST_IDX) begin
            state_d    = DONE;
            overflow_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pre-increment count gates the read, so a same-cycle write reads as 0.
  always_comb begin
    rd_word_d = '0;
    if (pc_in < wr_count_ext) begin
      rd_word_d = mem[pc_in[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_count_q <= '0;
      overflow_q <= 1'b0;
      rd_word_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      overflow_q <= overflow_d;
      rd_word_q  <= rd_word_d;
    end
  end

  // RAM is never cleared; stale contents are hidden behind wr_count.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_count_q[ADDR_W-1:0]] <= enc_word;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q == LOAD);
  assign done      = (state_q == DONE);
  assign overflow  = overflow_q;
  assign wr_count  = wr_count_q;
  assign format    = rd_word_q[8];
  assign opcode    = rd_word_q[7:4];
  assign sign      = rd_word_q[3];
  assign operand   = rd_word_q[2:0];
  assign immediate = rd_word_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_instr_prog_loader.sv
`default_nettype none
// ============================================================================
// tb_instr_prog_loader : directed + randomized bench with a queue-based model.
// Revision 1.0
// ============================================================================
module tb_instr_prog_loader;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic              in_format, in_use_imm, in_sign, in_last;
  logic [3:0]        in_opcode;
  logic [2:0]        in_operand;
  logic [7:0]        in_immediate;
  logic [15:0]       pc_in;
  logic              in_ready, busy, done, overflow;
  logic [ADDR_W:0]   wr_count;
  logic              format, sign;
  logic [3:0]        opcode;
  logic [2:0]        operand;
  logic [7:0]        immediate;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: the program is just the list of words accepted this session.
  logic [8:0] prog [$];
  bit loading, done_m, ovf_m;

  instr_prog_loader #(.ADDR_W(ADDR_W), .WORD_W(9)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_format(in_format), .in_use_imm(in_use_imm), .in_opcode(in_opcode),
    .in_sign(in_sign), .in_operand(in_operand), .in_immediate(in_immediate),
    .in_last(in_last), .busy(busy), .done(done), .overflow(overflow),
    .wr_count(wr_count), .pc_in(pc_in), .format(format), .opcode(opcode),
    .sign(sign), .operand(operand), .immediate(immediate)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] expected_word(input int pc);
    return (pc < prog.size()) ? prog[pc] : 9'h000;
  endfunction

  task automatic check_status(input string tag);
    check({tag, ":busy"},     32'(busy),     32'(loading));
    check({tag, ":in_ready"}, 32'(in_ready), 32'(loading));
    check({tag, ":done"},     32'(done),     32'(done_m));
    check({tag, ":overflow"}, 32'(overflow), 32'(ovf_m));
    check({tag, ":wr_count"}, 32'(wr_count), 32'(prog.size()));
  endtask

  task automatic check_fields(input string tag, input logic [8:0] w);
    check({tag, ":fmt_op_sign_opd"}, 32'({format, opcode, sign, operand}), 32'(w));
    check({tag, ":immediate"},       32'(immediate),                       32'(w[7:0]));
  endtask

  task automatic read_check(input string tag, input int pc);
    pc_in = 16'(pc);
    tick;
    check_fields(tag, expected_word(pc));
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    if (!loading) begin
      loading = 1'b1;
      done_m  = 1'b0;
      ovf_m   = 1'b0;
      prog.delete();
    end
  endtask

  // Presents one beat and leaves in_valid high; caller decides when to drop it.
  task automatic beat(input logic f, input logic u, input logic [3:0] op, input logic s,
                      input logic [2:0] opd, input logic [7:0] imm, input logic l);
    int waited;
    in_format = f; in_use_imm = u; in_opcode = op; in_sign = s;
    in_operand = opd; in_immediate = imm; in_last = l; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick;
      waited++;
    end
    check("beat_ready", 32'(in_ready), 32'd1);
    if (in_ready) begin
      tick;
      prog.push_back(u ? {f, imm} : {f, op, s, opd});
      if (l) begin
        loading = 1'b0; done_m = 1'b1;
      end else if (prog.size() == DEPTH) begin
        loading = 1'b0; done_m = 1'b1; ovf_m = 1'b1;
      end
    end
  endtask

  task automatic rand_beat(input logic l);
    beat(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
         3'($urandom), 8'($urandom), l);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_format = 1'b0; in_use_imm = 1'b0;
    in_opcode = '0; in_sign = 1'b0; in_operand = '0; in_immediate = '0; in_last = 1'b0;
    pc_in = '0;
    loading = 1'b0; done_m = 1'b0; ovf_m = 1'b0;
    tick;
    check_status("reset");
    check_fields("reset_rd", 9'h000);
    reset = 1'b0;
    tick;

    // Directed 3-word program
    pulse_start;
    check_status("start1");
    beat(1'b0, 1'b1, 4'h0, 1'b0, 3'h0, 8'h00, 1'b0);
    beat(1'b1, 1'b0, 4'h7, 1'b1, 3'h0, 8'h00, 1'b0);
    beat(1'b0, 1'b1, 4'h0, 1'b0, 3'h0, 8'h80, 1'b1);
    in_valid = 1'b0;
    tick;
    check_status("prog3");
    check("prog3_done", 32'(done), 32'd1);
    check("prog3_count", 32'(wr_count), 32'd3);
    read_check("pc0", 0);
    check_fields("pc0_const", 9'h000);
    read_check("pc1", 1);
    check_fields("pc1_const", 9'h178);
    check("pc1_format", 32'(format), 32'd1);
    check("pc1_opcode", 32'(opcode), 32'd7);
    read_check("pc2", 2);
    check_fields("pc2_const", 9'h080);
    read_check("pc3", 3);

    // Continuous-valid fill to overflow
    pulse_start;
    check_status("start_ovf");
    for (int i = 0; i < DEPTH; i++) rand_beat(1'b0);
    check_status("full");
    check("full_count", 32'(wr_count), 32'd128);
    check("full_ovf", 32'(overflow), 32'd1);
    in_immediate = 8'h5a;
    repeat (3) tick;
    check_status("beat129");
    in_valid = 1'b0;
    read_check("pc200", 200);
    check_fields("pc200_const", 9'h000);
    read_check("pc127", 127);
    read_check("pc0_full", 0);
    for (int i = 0; i < 6; i++) read_check("pc_rand", int'($urandom_range(0, 255)));

    // start in DONE clears overflow; then gapped valid
    pulse_start;
    check_status("start_from_done");
    check("restart_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) begin
      rand_beat(1'(i == 4));
      in_valid = 1'b0;
      tick;
    end
    check_status("gapped");
    check("gapped_count", 32'(wr_count), 32'd5);
    for (int i = 0; i < 6; i++) read_check("gapped_rd", i);

    // Async reset mid-load
    pulse_start;
    for (int i = 0; i < 10; i++) rand_beat(1'b0);
    in_valid = 1'b0;
    pc_in = 16'd3;
    tick;
    check_fields("pre_reset_rd", expected_word(3));
    #2 reset = 1'b1;
    #1;
    prog.delete(); loading = 1'b0; done_m = 1'b0; ovf_m = 1'b0;
    check_status("async_reset");
    check_fields("async_reset_rd", 9'h000);
    #1 reset = 1'b0;
    read_check("post_reset_pc0", 0);
    pulse_start;
    rand_beat(1'b0);
    rand_beat(1'b1);
    in_valid = 1'b0;
    tick;
    check_status("fresh2");
    read_check("fresh2_pc0", 0);
    read_check("fresh2_pc1", 1);

    // start ignored during LOAD
    pulse_start;
    for (int i = 0; i < 4; i++) rand_beat(1'b0);
    in_valid = 1'b0;
    pulse_start;
    check_status("start_in_load");
    check("start_in_load_count", 32'(wr_count), 32'd4);
    rand_beat(1'b0);
    rand_beat(1'b1);
    in_valid = 1'b0;
    tick;
    check_status("after_ignored_start");
    for (int i = 0; i < 7; i++) read_check("six_rd", i);

    // Same-cycle write/read of address 0
    pulse_start;
    check_status("start_same_cycle");
    pc_in = 16'd0;
    rand_beat(1'b0);
    in_valid = 1'b0;
    check_fields("rbw_first", 9'h000);
    tick;
    check_fields("rbw_second", prog[0]);
    check_status("rbw_status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
